// File: rtl/vga_arb_pkg.sv
// Shared definitions for the VGA plot arbiter.
// Holds screen geometry, engine count, engine index constants, the arbiter FSM state type
// and a one-hot to index helper. Imported by rr_pick3 and vga_plot_arbiter.
package vga_arb_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned NUM_ENG  = 3;

    // Engine slots on the req/gnt vectors
    localparam int unsigned ENG_FILL     = 0;
    localparam int unsigned ENG_CIRCLE   = 1;
    localparam int unsigned ENG_REULEAUX = 2;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StRelease
    } arb_state_e;

    // Index of the set bit in a one-hot engine vector; 0 when nothing is set.
    function automatic logic [1:0] eng_idx(input logic [NUM_ENG-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker, purely combinational.
// Searches the request vector starting one slot above the last-granted engine and wraps.
// Ports:
//   req_i  [2:0]  pending requests
//   ptr_i  [1:0]  index of the last-granted engine
//   pick_o [2:0]  one-hot winner, all zero when no request is pending
module rr_pick3
    import vga_arb_pkg::*;
(
    input  logic [NUM_ENG-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_ENG-1:0] pick_o
);

    always_comb begin
        pick_o = '0;
        case (ptr_i)
            2'd0: begin
                if      (req_i[1]) pick_o = 3'b010;
                else if (req_i[2]) pick_o = 3'b100;
                else if (req_i[0]) pick_o = 3'b001;
            end
            2'd1: begin
                if      (req_i[2]) pick_o = 3'b100;
                else if (req_i[0]) pick_o = 3'b001;
                else if (req_i[1]) pick_o = 3'b010;
            end
            // Pointer at engine 2 (also the unused code 3): engine 0 goes first.
            default: begin
                if      (req_i[0]) pick_o = 3'b001;
                else if (req_i[1]) pick_o = 3'b010;
                else if (req_i[2]) pick_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Arbitrates three drawing engines (fillscreen, circle, reuleaux) onto one VGA plot port.
// One engine owns the port for a whole job: grant in IDLE, run in BUSY until its done,
// then hold the grant in RELEASE until done falls so the engine sees a clean handshake.
// Optional build macro: VGA_ARB_CLIP_EN -- suppress vga_plot for off-screen coordinates.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req[2:0]                  per-engine job request
//   gnt[2:0], eng_start[2:0]  one-hot grant / engine start (registered)
//   eng_done[2:0]             per-engine job done
//   eng_x/eng_y/eng_colour    per-engine pixel data (3x8, 3x7, 3x3)
//   eng_plot[2:0]             per-engine plot strobe
//   vga_x/vga_y/vga_colour    muxed pixel data to the VGA core
//   vga_plot                  muxed plot strobe to the VGA core
//   ack[2:0]                  one-cycle pulse when the granted job completes
//   busy                      high whenever the FSM is not idle
module vga_plot_arbiter
    import vga_arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_ENG-1:0]       req,
    output logic [NUM_ENG-1:0]       gnt,
    output logic [NUM_ENG-1:0]       eng_start,
    input  logic [NUM_ENG-1:0]       eng_done,
    input  logic [NUM_ENG-1:0][7:0]  eng_x,
    input  logic [NUM_ENG-1:0][6:0]  eng_y,
    input  logic [NUM_ENG-1:0][2:0]  eng_colour,
    input  logic [NUM_ENG-1:0]       eng_plot,
    output logic [7:0]               vga_x,
    output logic [6:0]               vga_y,
    output logic [2:0]               vga_colour,
    output logic                     vga_plot,
    output logic [NUM_ENG-1:0]       ack,
    output logic                     busy
);

    arb_state_e         state_q;
    logic [NUM_ENG-1:0] gnt_q;
    logic [NUM_ENG-1:0] start_q;
    logic [NUM_ENG-1:0] ack_q;
    logic [1:0]         ptr_q;
    logic [NUM_ENG-1:0] pick;
    logic               done_g;

    logic [1:0]         g;
    logic [7:0]         mux_x;
    logic [6:0]         mux_y;
    logic [2:0]         mux_colour;
    logic               mux_plot;
    logic               in_screen;

    rr_pick3 u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick)
    );

    assign done_g = |(eng_done & gnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            start_q <= '0;
            ack_q   <= '0;
            ptr_q   <= 2'(ENG_REULEAUX);
        end else begin
            ack_q <= '0;
            case (state_q)
                StIdle: begin
                    if (req != '0) begin
                        gnt_q   <= pick;
                        start_q <= pick;
                        ptr_q   <= eng_idx(pick);
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    // Requests are ignored here; only done ends the job.
                    if (done_g) begin
                        start_q <= '0;
                        ack_q   <= gnt_q;
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    if (!done_g) begin
                        gnt_q   <= '0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    start_q <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Pixel path is combinational so plots land in the same cycle the engine drives them.
    always_comb begin
        g          = eng_idx(gnt_q);
        mux_x      = eng_x[g];
        mux_y      = eng_y[g];
        mux_colour = eng_colour[g];
        mux_plot   = eng_plot[g];
    end

`ifdef VGA_ARB_CLIP_EN
    assign in_screen = (mux_x < 8'(SCREEN_W)) && (mux_y < 7'(SCREEN_H));
`else
    assign in_screen = 1'b1;
`endif

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (state_q == StBusy) begin
            vga_x      = mux_x;
            vga_y      = mux_y;
            vga_colour = mux_colour;
            vga_plot   = mux_plot & in_screen;
        end
    end

    assign gnt       = gnt_q;
    assign eng_start = start_q;
    assign ack       = ack_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed self-checking bench for vga_plot_arbiter.
module tb_vga_plot_arbiter;

    logic            clk;
    logic            rst;
    logic [2:0]      req;
    logic [2:0]      gnt;
    logic [2:0]      eng_start;
    logic [2:0]      eng_done;
    logic [2:0][7:0] eng_x;
    logic [2:0][6:0] eng_y;
    logic [2:0][2:0] eng_colour;
    logic [2:0]      eng_plot;
    logic [7:0]      vga_x;
    logic [6:0]      vga_y;
    logic [2:0]      vga_colour;
    logic            vga_plot;
    logic [2:0]      ack;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int nplot;

    vga_plot_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_colour (eng_colour),
        .eng_plot   (eng_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .ack        (ack),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Finish the job of engine g: done pulse, release hold, return to idle.
    task automatic finish_job(input logic [2:0] g, input string tag);
        eng_done = g;
        step();
        chk({tag, "_ack"}, ack, g);
        chk({tag, "_start_drop"}, eng_start, 3'b000);
        chk({tag, "_busy_rel"}, busy, 1'b1);
        step();
        chk({tag, "_ack_once"}, ack, 3'b000);
        chk({tag, "_gnt_hold"}, gnt, g);
        eng_done = 3'b000;
        step();
        chk({tag, "_gnt_free"}, gnt, 3'b000);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    logic [2:0] seq [4];
    logic       pat [5];
    logic       clip_exp [3];

    initial begin
        seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef VGA_ARB_CLIP_EN
        clip_exp = '{1'b1, 1'b0, 1'b0};
`else
        clip_exp = '{1'b1, 1'b1, 1'b1};
`endif
        rst        = 1'b1;
        req        = '0;
        eng_done   = '0;
        eng_x      = '0;
        eng_y      = '0;
        eng_colour = '0;
        eng_plot   = '0;

        // Reset state
        #2;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_start", eng_start, 3'b000);
        chk("rst_ack", ack, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_plot", vga_plot, 1'b0);
        step();
        rst = 1'b0;

        // A: single fillscreen job of 19200 plots
        req = 3'b001;
        #1;
        chk("A_gnt_pre", gnt, 3'b000);
        step();
        chk("A_gnt", gnt, 3'b001);
        chk("A_start", eng_start, 3'b001);
        chk("A_busy", busy, 1'b1);
        nplot = 0;
        for (int i = 0; i < 19200; i++) begin
            eng_plot      = 3'b001;
            eng_x[0]      = 8'(i % 160);
            eng_y[0]      = 7'(i / 160);
            eng_colour[0] = 3'(i % 8);
            #1;
            if (vga_plot) nplot++;
            if (i == 777) begin
                chk("A_x", vga_x, 8'd137);
                chk("A_y", vga_y, 7'd4);
                chk("A_col", vga_colour, 3'd1);
            end
            step();
        end
        chk("A_nplot", nplot, 19200);
        eng_plot = 3'b000;
        req      = 3'b000;
        finish_job(3'b001, "A");
        chk("A_x_idle", vga_x, 8'd0);

        // B: all three requesting, round-robin from a fresh reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("B_gnt", gnt, seq[k]);
            chk("B_start", eng_start, seq[k]);
            finish_job(seq[k], "B");
        end
        req = 3'b000;

        // C: engine 1 granted, engine 2 plotting continuously
        req        = 3'b110;
        eng_x[1]   = 8'd10;
        eng_x[2]   = 8'd200;
        step();
        chk("C_gnt", gnt, 3'b010);
        for (int k = 0; k < 5; k++) begin
            eng_plot = {1'b1, pat[k], 1'b0};
            #1;
            chk("C_plot", vga_plot, pat[k]);
            if (k == 0) chk("C_x", vga_x, 8'd10);
            step();
        end
        eng_plot = 3'b000;
        req      = 3'b000;
        finish_job(3'b010, "C");

        // D: reset mid-job at plot 500
        req = 3'b001;
        step();
        chk("D_gnt", gnt, 3'b001);
        for (int i = 0; i < 500; i++) begin
            eng_plot = 3'b001;
            step();
        end
        #1;
        chk("D_plot_pre", vga_plot, 1'b1);
        rst = 1'b1;
        #1;
        chk("D_gnt_rst", gnt, 3'b000);
        chk("D_start_rst", eng_start, 3'b000);
        chk("D_plot_rst", vga_plot, 1'b0);
        chk("D_ack_rst", ack, 3'b000);
        chk("D_busy_rst", busy, 1'b0);
        #1;
        rst      = 1'b0;
        eng_plot = 3'b000;
        req      = 3'b111;
        step();
        chk("D_ack_after", ack, 3'b000);
        chk("D_regnt", gnt, 3'b001);
        finish_job(3'b001, "D");
        req = 3'b000;

        // E: clip boundary coordinates on engine 1
        req = 3'b010;
        step();
        chk("E_gnt", gnt, 3'b010);
        req      = 3'b000;
        eng_plot = 3'b010;
        eng_x[1] = 8'd159;
        eng_y[1] = 7'd119;
        #1;
        chk("E_plot_in", vga_plot, clip_exp[0]);
        step();
        eng_x[1] = 8'd160;
        eng_y[1] = 7'd5;
        #1;
        chk("E_plot_x", vga_plot, clip_exp[1]);
        step();
        eng_x[1] = 8'd3;
        eng_y[1] = 7'd120;
        #1;
        chk("E_plot_y", vga_plot, clip_exp[2]);
        step();
        eng_plot = 3'b000;
        finish_job(3'b010, "E");

        // F: request dropped after grant, job still completes
        req = 3'b001;
        step();
        chk("F_gnt", gnt, 3'b001);
        req = 3'b000;
        step();
        step();
        chk("F_gnt_held", gnt, 3'b001);
        chk("F_start_held", eng_start, 3'b001);
        chk("F_busy", busy, 1'b1);
        finish_job(3'b001, "F");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 The block SHALL be clocked by the single clock `clk`, rising edge.
REQ-002 The block SHALL use reset `rst`: asynchronous, active-high.
REQ-003 Ports SHALL be exactly:
- `clk`  in  1  clock
- `rst`  in  1  async active-high reset
- `req`  in  3  per-engine job request; engines 0/1/2 = fillscreen/circle/reuleaux
- `gnt`  out  3  one-hot grant, held for the whole job
- `eng_start`  out  3  start to each engine, held high while that engine is granted and running
- `eng_done`  in  3  per-engine done
- `eng_x`  in  3x8  per-engine x
- `eng_y`  in  3x7  per-engine y
- `eng_colour`  in  3x3  per-engine colour
- `eng_plot`  in  3  per-engine plot strobe
- `vga_x`  out  8  to VGA core
- `vga_y`  out  7  to VGA core
- `vga_colour`  out  3  to VGA core
- `vga_plot`  out  1  to VGA core
- `ack`  out  3  one-cycle pulse when the granted job completes
- `busy`  out  1  high in any state other than IDLE

Function
REQ-004 FSM states SHALL be IDLE, BUSY and RELEASE only.
REQ-005 IDLE with `req`≠0 at edge n SHALL select one engine by round-robin and enter BUSY; `gnt` and `eng_start` for that engine SHALL be high from edge n (1-cycle latency from request to start).
REQ-006 Round-robin SHALL search from (last granted + 1) mod 3 upward. The pointer SHALL update on every grant.
REQ-007 Simultaneous requests SHALL be resolved only by REQ-006; the losers SHALL remain pending and need no re-assertion while held.
REQ-008 In BUSY:
- `vga_x`/`vga_y`/`vga_colour` SHALL equal the granted engine's inputs, combinationally.
- `vga_plot` SHALL equal `eng_plot[g]`.
- Plot strobes from non-granted engines SHALL be ignored.
REQ-009 Deassertion of `req[g]` during BUSY SHALL be ignored; the job SHALL run to `eng_done[g]`.
REQ-010 BUSY with `eng_done[g]`=1 at edge:
- next state SHALL be RELEASE;
- `eng_start[g]` SHALL drop;
- `ack[g]` SHALL pulse for exactly 1 cycle.
REQ-011 RELEASE SHALL hold `gnt[g]` until `eng_done[g]`=0, then return to IDLE. A new grant SHALL occur no earlier than the cycle after IDLE is re-entered.
REQ-012 Outside BUSY, `vga_plot` SHALL be 0, `vga_x`/`vga_y`/`vga_colour` SHALL be 0, and `eng_start` SHALL be 0.
REQ-013 `gnt` and `eng_start` SHALL never have more than one bit set.

Reset
REQ-014 `rst` high SHALL, immediately and independent of `clk`, force:
- state to IDLE;
- `gnt`, `eng_start`, `ack`, `busy` and `vga_plot` to 0;
- the round-robin pointer to 2, so engine 0 has first priority.
REQ-015 A reset applied mid-job SHALL abandon the job with no `ack`. The engine's `start` SHALL drop asynchronously.

Configuration
REQ-016 With macro `VGA_ARB_CLIP_EN` defined, `vga_plot` SHALL be suppressed when the muxed x≥160 or y≥120.
REQ-017 Without `VGA_ARB_CLIP_EN`, all granted plots SHALL pass unfiltered.

Structure
REQ-018 Package `vga_arb_pkg` SHALL hold:
- SCREEN_W=160 and SCREEN_H=120;
- NUM_ENG=3;
- the FSM state enum;
- engine index constants.
REQ-019 The round-robin selection SHALL be a sub-module `rr_pick3`: inputs `req` and pointer, output one-hot pick. It SHALL be purely combinational.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset then `req`=3'b001, model engine done after 19200 plots: `gnt`=001 one cycle after request; 19200 `vga_plot` pulses; `ack`=001 once; `busy` low after `eng_done` falls.
- `req`=3'b111 held: grants in order 001, 010, 100, 001; each `ack` pulses once per job.
- Engine 1 granted, engine 2 drives `eng_plot`=1 continuously: `vga_plot` tracks only `eng_plot[1]`.
- `rst` pulsed mid-job at plot 500: `gnt`, `eng_start`, `vga_plot` are 0 within the same cycle; no `ack`; next grant goes to engine 0.
- With `VGA_ARB_CLIP_EN`, engine plots (159,119), then (160,5), then (3,120): only the first reaches `vga_plot`. Without the macro, all three do.
- `req[0]` dropped after grant: job still completes and `ack[0]` pulses.
